// File: rtl/integrate_dump_accumulator_if.sv
// Valid/ready stream bundle used on both sides of the integrate-and-dump block.
//   data  : payload, W bits
//   valid : producer has a word on data
//   ready : consumer takes the word this cycle
// master drives data/valid, slave drives ready.
interface integrate_dump_accumulator_if #(
  parameter int W = 16
);
  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport master (output data, output valid, input  ready);
  modport slave  (input  data, input  valid, output ready);
endinterface

// File: rtl/integrate_dump_accumulator.sv
// Streaming integrate-and-dump decimator.
// Sums DECIM consecutive accepted samples into an exact, growth-widened word
// (WIDTH_IN + clog2(DECIM) bits) and emits one word per block through a
// single-entry output register that absorbs downstream backpressure.
// Ports:
//   clk    : clock, all state on the rising edge
//   rst_n  : asynchronous active-low reset
//   ena    : accept-enable; 0 = no input accepted (output side keeps working)
//   clr    : synchronous flush of the partial sum and any pending result
//   s_in   : input sample stream  (data=din, valid=din_valid, ready=din_ready)
//   m_out  : block sum stream     (data=dout, valid=dout_valid, ready=dout_ready)
module integrate_dump_accumulator #(
  parameter int WIDTH_IN  = 16,
  parameter int DECIM     = 8,
  parameter int IS_SIGNED = 1,
  localparam int WIDTH_OUT = WIDTH_IN + $clog2(DECIM)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic clr,
  integrate_dump_accumulator_if.slave  s_in,
  integrate_dump_accumulator_if.master m_out
);

  localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;

  if (DECIM < 1) begin : g_bad_decim
    $error("integrate_dump_accumulator: DECIM must be >= 1");
  end
  if (WIDTH_IN < 2) begin : g_bad_width
    $error("integrate_dump_accumulator: WIDTH_IN must be >= 2");
  end

  logic [WIDTH_OUT-1:0] acc;
  logic [CNT_W-1:0]     cnt;
  logic [WIDTH_OUT-1:0] dout_q;
  logic                 dout_vld_q;

  logic [WIDTH_OUT-1:0] ext;
  logic [WIDTH_OUT-1:0] sum;
  logic                 last;
  logic                 din_rdy;
  logic                 accept;
  logic                 dump;
  logic                 consume;

  // Width growth is exact, so extension + add can never overflow.
  if (IS_SIGNED != 0) begin : g_sext
    assign ext = WIDTH_OUT'($signed(s_in.data));
  end else begin : g_zext
    assign ext = WIDTH_OUT'(s_in.data);
  end

  assign sum  = acc + ext;
  assign last = (cnt == CNT_W'(DECIM - 1));

  // Only the block-closing sample needs room in the output register; partial
  // accumulation proceeds even while a result waits downstream.
  assign din_rdy = ena & ~clr & (~last | ~dout_vld_q | m_out.ready);
  assign accept  = s_in.valid & din_rdy;
  assign dump    = accept & last;
  assign consume = dout_vld_q & m_out.ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      cnt        <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
    end else if (clr) begin
      // Pending result is dropped but dout keeps its last value.
      acc        <= '0;
      cnt        <= '0;
      dout_vld_q <= 1'b0;
    end else begin
      if (dump) begin
        dout_q <= sum;
        acc    <= '0;
        cnt    <= '0;
      end else if (accept) begin
        acc <= sum;
        cnt <= cnt + CNT_W'(1);
      end
      // A dump in the same cycle as a consume refills the register: no bubble.
      if (dump)         dout_vld_q <= 1'b1;
      else if (consume) dout_vld_q <= 1'b0;
    end
  end

  assign s_in.ready  = din_rdy;
  assign m_out.data  = dout_q;
  assign m_out.valid = dout_vld_q;

endmodule

// File: tb/tb_integrate_dump_accumulator.sv
// Bench for integrate_dump_accumulator: four instances with different
// DECIM / signedness, each with a scoreboard queue filled on block completion
// and drained on output handshakes, plus directed checks of known sums.
module tb_integrate_dump_accumulator;

  localparam int N = 4;
  localparam int DL [N] = '{4, 8, 2, 1};
  localparam int SL [N] = '{1, 1, 0, 0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] ena, clr, din_valid, dout_ready;
  logic [15:0]  din [N];
  wire  [N-1:0] din_ready, dout_valid;
  wire  [63:0]  dout_l [N];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < N; g++) begin : u
    localparam int D  = DL[g];
    localparam int S  = SL[g];
    localparam int WO = 16 + $clog2(D);

    integrate_dump_accumulator_if #(.W(16)) ifi ();
    integrate_dump_accumulator_if #(.W(WO)) ifo ();

    assign ifi.data      = din[g];
    assign ifi.valid     = din_valid[g];
    assign din_ready[g]  = ifi.ready;
    assign ifo.ready     = dout_ready[g];
    assign dout_valid[g] = ifo.valid;
    if (S != 0) begin : g_s
      assign dout_l[g] = 64'($signed(ifo.data));
    end else begin : g_u
      assign dout_l[g] = 64'(ifo.data);
    end

    integrate_dump_accumulator #(.WIDTH_IN(16), .DECIM(D), .IS_SIGNED(S)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ena   (ena[g]),
      .clr   (clr[g]),
      .s_in  (ifi.slave),
      .m_out (ifo.master)
    );

    longint q[$];
    longint msum;
    longint e;
    longint last_out;
    int     mcnt;

    initial begin
      msum = 0; mcnt = 0; last_out = 0; e = 0;
    end

    always @(negedge clk) begin
      if (!rst_n) begin
        q.delete(); msum = 0; mcnt = 0;
      end else begin
        chk($sformatf("dv%0d", g), longint'(dout_valid[g]), longint'(q.size() != 0));
        chk($sformatf("rdy%0d", g), longint'(din_ready[g]),
            longint'(ena[g] && !clr[g] && (mcnt != D-1 || q.size() == 0 || dout_ready[g])));
        if (clr[g]) begin
          q.delete(); msum = 0; mcnt = 0;
        end else begin
          if (dout_valid[g] && dout_ready[g] && q.size() != 0) begin
            last_out = longint'(dout_l[g]);
            chk($sformatf("dout%0d", g), last_out, q.pop_front());
          end
          if (din_valid[g] && din_ready[g]) begin
            e = (S != 0) ? longint'($signed(din[g])) : longint'(din[g]);
            msum += e;
            mcnt++;
            if (mcnt == D) begin
              q.push_back(msum); msum = 0; mcnt = 0;
            end
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input int g, input logic [15:0] v);
    bit ok = 1'b0;
    din[g] = v; din_valid[g] = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk); ok = din_ready[g];
      @(posedge clk); #1;
    end
    din_valid[g] = 1'b0;
    if (!ok) chk($sformatf("send_timeout%0d", g), 0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  initial begin
    ena = '1; clr = '0; din_valid = '0; dout_ready = '1;
    for (int i = 0; i < N; i++) din[i] = '0;

    #2;
    for (int g = 0; g < N; g++) begin
      chk($sformatf("rst_dout%0d", g), longint'(dout_l[g]), 0);
      chk($sformatf("rst_dv%0d", g), longint'(dout_valid[g]), 0);
    end
    #20 rst_n = 1'b1;
    step(1);

    // 1: 1+2+3+4, valid exactly one cycle
    for (int i = 1; i <= 4; i++) send(0, 16'(i));
    @(negedge clk);
    chk("t1_dv", longint'(dout_valid[0]), 1);
    chk("t1_sum", longint'(dout_l[0]), 10);
    @(negedge clk);
    chk("t1_dv_drop", longint'(dout_valid[0]), 0);
    step(1);

    // 2: signed extremes, DECIM=8, 19-bit result
    for (int i = 0; i < 8; i++) send(1, 16'h8000);
    step(2);
    chk("t2_min", u[1].last_out, -262144);
    for (int i = 0; i < 8; i++) send(1, 16'h7FFF);
    step(2);
    chk("t2_max", u[1].last_out, 262136);

    // 6: unsigned DECIM=2 and DECIM=1
    send(2, 16'hFFFF); send(2, 16'hFFFF);
    step(2);
    chk("t6_d2", u[2].last_out, 131070);
    send(3, 16'h8000);
    @(negedge clk);
    chk("t6_d1_dv", longint'(dout_valid[3]), 1);
    chk("t6_d1", longint'(dout_l[3]), 32768);
    step(1);

    // 3: backpressure stalls only the block-closing sample
    dout_ready[0] = 1'b0;
    send(0, 16'd10); send(0, 16'd20); send(0, 16'd30); send(0, 16'd40);
    send(0, 16'hFFFF); send(0, 16'hFFFE); send(0, 16'hFFFD);
    din[0] = 16'hFFFC; din_valid[0] = 1'b1;
    @(negedge clk);
    chk("t3_stall_a", longint'(din_ready[0]), 0);
    chk("t3_hold_a", longint'(dout_l[0]), 100);
    step(1);
    @(negedge clk);
    chk("t3_stall_b", longint'(din_ready[0]), 0);
    chk("t3_hold_b", longint'(dout_l[0]), 100);
    step(1);
    dout_ready[0] = 1'b1;
    @(negedge clk);
    chk("t3_release", longint'(din_ready[0]), 1);
    @(posedge clk); #1;
    din_valid[0] = 1'b0;
    @(negedge clk);
    chk("t3_sum2_dv", longint'(dout_valid[0]), 1);
    chk("t3_sum2", longint'(dout_l[0]), -10);
    step(1);
    chk("t3_first", u[0].q.size() == 0 ? u[0].last_out : 0, -10);

    // 4: clear mid-block, then clear a pending result
    send(0, 16'd7); send(0, 16'd7);
    clr[0] = 1'b1; step(1); clr[0] = 1'b0;
    for (int i = 0; i < 4; i++) send(0, 16'd5);
    step(2);
    chk("t4_sum", u[0].last_out, 20);
    dout_ready[0] = 1'b0;
    for (int i = 1; i <= 4; i++) send(0, 16'(i));
    @(negedge clk);
    chk("t4_pend", longint'(dout_valid[0]), 1);
    step(1);
    clr[0] = 1'b1; step(1); clr[0] = 1'b0;
    chk("t4_clr_dv", longint'(dout_valid[0]), 0);
    chk("t4_clr_dout", longint'(dout_l[0]), 10);
    dout_ready[0] = 1'b1;
    step(2);

    // ena=0 blocks input
    ena[0] = 1'b0; din[0] = 16'd9; din_valid[0] = 1'b1;
    @(negedge clk);
    chk("ena_off", longint'(din_ready[0]), 0);
    step(2);
    din_valid[0] = 1'b0; ena[0] = 1'b1;

    // 5: async reset between edges mid-block with a pending result
    dout_ready[0] = 1'b0;
    for (int i = 1; i <= 4; i++) send(0, 16'(i));
    send(0, 16'd1); send(0, 16'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_dout", longint'(dout_l[0]), 0);
    chk("t5_rst_dv", longint'(dout_valid[0]), 0);
    step(1);
    #1 rst_n = 1'b1;
    step(1);
    dout_ready[0] = 1'b1;
    for (int i = 0; i < 4; i++) send(0, 16'd1);
    step(2);
    chk("t5_sum", u[0].last_out, 4);

    step(3);
    chk("drain0", longint'(u[0].q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
